gi_mac_sched: RTL and testbench

//   Sequencer for the 121-tap (11x11) bilateral-filter product stage. Replaces
//   the fully parallel multiplier array with one time-shared g*i MAC.
//   Per accepted job it reads TAPS (weight g, intensity i) pairs from a window

---
 rtl/gi_mac_sched.sv | 68 ++++++
 tb/tb_gi_mac_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gi_mac_sched.sv
// gi_mac_sched: sequences one time-shared g*i MAC over a tap window and
// hands the numerator/denominator sums to the divider via valid/ready.
module gi_mac_sched #(
    parameter int TAPS = 121,
    parameter int GW   = 14,
    parameter int IW   = 8,
    parameter int AW   = 7,
    parameter int NW   = 29,
    parameter int DW   = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          abort,
    output logic          tap_rd,
    output logic [AW-1:0] tap_addr,
    input  logic [GW-1:0] tap_g,
    input  logic [IW-1:0] tap_i,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [NW-1:0] res_num,
    output logic [DW-1:0] res_den
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic last, accept, acc;
    assign last   = tap_addr == AW'(TAPS - 1);
    assign accept = state == IDLE && start_valid;
    // Read data lags its address by one cycle, so the sum trails the issue by one tap
    assign acc    = !abort && ((state == RUN && tap_addr != '0) || state == DRAIN);
    always_comb begin
        state_n = state;
        state_n = (state != IDLE && abort) ? IDLE :
                  (state == IDLE)  ? (start_valid ? RUN : IDLE) :
                  (state == RUN)   ? (last ? DRAIN : RUN) :
                  (state == DRAIN) ? DONE :
                  (res_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tap_addr    <= '0;
            tap_rd      <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            res_num     <= '0;
            res_den     <= '0;
        end else begin
            state       <= state_n;
            tap_rd      <= state_n == RUN;
            res_valid   <= state_n == DONE;
            busy        <= state_n != IDLE;
            start_ready <= state_n == IDLE;
            tap_addr    <= accept ? '0 :
                           (state == RUN && !abort && !last) ? tap_addr + 1'b1 : tap_addr;
            if (accept) begin
                res_num <= '0;
                res_den <= '0;
            end else if (acc) begin
                res_num <= res_num + NW'(tap_g) * NW'(tap_i);
                res_den <= res_den + DW'(tap_g);
            end
        end
    end
endmodule

// File: tb/tb_gi_mac_sched.sv
// tb_gi_mac_sched: randomized and directed jobs checked cycle-by-cycle against
// a job-timeline model (cycles since acceptance) plus literal sums.
module tb_gi_mac_sched;
    localparam int TAPS = 121, GW = 14, IW = 8, AW = 7, NW = 29, DW = 21;
    logic          clk = 0, rst = 1, start_valid = 0, abort = 0, res_ready = 0;
    logic          start_ready, tap_rd, busy, res_valid;
    logic [AW-1:0] tap_addr;
    logic [GW-1:0] tap_g = '0;
    logic [IW-1:0] tap_i = '0;
    logic [NW-1:0] res_num;
    logic [DW-1:0] res_den;
    int gm[TAPS], im[TAPS];
    int vectors = 0, miscompares = 0;
    int t = 0;
    longint num_e = 0, den_e = 0;
    bit live = 0;

    gi_mac_sched dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .abort(abort), .tap_rd(tap_rd), .tap_addr(tap_addr), .tap_g(tap_g),
        .tap_i(tap_i), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_num(res_num), .res_den(res_den)
    );

    always #5 clk = ~clk;

    // Window store: one-cycle read latency, junk when not read
    always @(posedge clk) begin
        tap_g <= tap_rd ? GW'(gm[tap_addr]) : GW'($urandom);
        tap_i <= tap_rd ? IW'(im[tap_addr]) : IW'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t = cycles since the accepting edge, 0 when idle
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            live = 1;
        end else if (t == 0) begin
            if (start_valid) begin
                t = 1;
                num_e = 0;
                den_e = 0;
                for (int k = 0; k < TAPS; k++) begin
                    num_e += longint'(gm[k]) * longint'(im[k]);
                    den_e += longint'(gm[k]);
                end
            end
        end else if (abort) t = 0;
        else if (t == TAPS + 2) begin
            if (res_ready) t = 0;
        end else t++;
    end

    always @(negedge clk) begin
        if (live) begin
            check("start_ready", start_ready, t == 0);
            check("busy", busy, t != 0);
            check("tap_rd", tap_rd, t >= 1 && t <= TAPS);
            check("res_valid", res_valid, t == TAPS + 2);
            if (t >= 1 && t <= TAPS) check("tap_addr", tap_addr, t - 1);
            if (t == TAPS + 2) begin
                check("res_num", res_num, num_e);
                check("res_den", res_den, den_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input int g, input int i, input int mode);
        for (int k = 0; k < TAPS; k++) begin
            gm[k] = mode == 1 ? k : mode == 2 ? int'($urandom_range(0, 16383)) : g;
            im[k] = mode == 2 ? int'($urandom_range(0, 255)) : i;
        end
    endtask

    task automatic start_job();
        start_valid = 1;
        step();
        start_valid = 0;
    endtask

    task automatic wait_valid(output int n, output int rdc);
        n = 0;
        rdc = 0;
        while (!res_valid && n < 300) begin
            rdc += int'(tap_rd);
            step();
            n++;
        end
        if (!res_valid) check("res_valid_timeout", 0, 1);
    endtask

    task automatic release_result(input int hold);
        res_ready = 0;
        repeat (hold) begin
            start_valid = $urandom_range(0, 1);
            step();
        end
        start_valid = 0;
        res_ready = 1;
        step();
        res_ready = 0;
    endtask

    initial begin
        int n, rdc;
        repeat (3) step();
        rst = 0;
        check("rst_num", res_num, 0);
        check("rst_den", res_den, 0);
        check("rst_start_ready", start_ready, 1);
        check("rst_tap_rd", tap_rd, 0);
        step();

        fill(1, 1, 0);
        start_job();
        wait_valid(n, rdc);
        check("t1_latency", n, TAPS + 1);
        check("t1_rd_pulses", rdc, 121);
        check("t1_num", res_num, 121);
        check("t1_den", res_den, 121);
        release_result(0);

        fill(16383, 255, 0);
        start_job();
        wait_valid(n, rdc);
        check("t2_num", res_num, 505497465);
        check("t2_den", res_den, 1982343);
        release_result(2);

        fill(0, 1, 1);
        start_job();
        wait_valid(n, rdc);
        release_result(10);
        check("t3_num", res_num, 7260);
        check("t3_den", res_den, 7260);

        fill(1, 1, 0);
        res_ready = 1;
        start_valid = 1;
        step();
        wait_valid(n, rdc);
        check("t4_job1_num", res_num, 121);
        fill(2, 3, 0);
        step();
        check("t4_gap_idle", start_ready, 1);
        step();
        check("t4_job2_busy", busy, 1);
        start_valid = 0;
        wait_valid(n, rdc);
        check("t4_num", res_num, 726);
        check("t4_den", res_den, 242);
        step();
        res_ready = 0;
        step();

        fill(5, 7, 0);
        start_job();
        n = 0;
        while (tap_addr != 60 && n < 200) begin step(); n++; end
        check("t5_reach60", tap_addr, 60);
        rst = 1;
        step();
        rst = 0;
        check("t5_tap_rd", tap_rd, 0);
        check("t5_tap_addr", tap_addr, 0);
        check("t5_busy", busy, 0);
        check("t5_res_valid", res_valid, 0);
        check("t5_num", res_num, 0);
        check("t5_den", res_den, 0);
        fill(1, 1, 0);
        start_job();
        wait_valid(n, rdc);
        check("t5_after_num", res_num, 121);
        release_result(1);

        start_job();
        repeat (30) step();
        abort = 1;
        step();
        abort = 0;
        check("t6_run_rd", tap_rd, 0);
        check("t6_run_busy", busy, 0);
        repeat (5) step();
        start_job();
        wait_valid(n, rdc);
        abort = 1;
        res_ready = 1;
        step();
        abort = 0;
        res_ready = 0;
        check("t6_done_valid", res_valid, 0);
        check("t6_done_ready", start_ready, 1);
        step();

        for (int j = 0; j < 10; j++) begin
            fill(0, 0, 2);
            start_job();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, TAPS + 3)) step();
                abort = 1;
                step();
                abort = 0;
                step();
            end else begin
                wait_valid(n, rdc);
                release_result($urandom_range(0, 6));
            end
            repeat ($urandom_range(0, 3)) step();
        end
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
